// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester, read-return and BRAM signals of the vector RAM arbiter
interface vram_arbiter_if #(
    parameter int ADDR_W = 13
);
    logic              cpu_req;
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic              vg_req;
    logic [ADDR_W-1:0] vg_addr;
    logic              vg_ack;
    logic              vg_rvalid;
    logic [7:0]        vg_rdata;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_din;
    logic [7:0]        bram_dout;
    logic              cpu_starved;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, vg_req, vg_addr, bram_dout,
        output cpu_ack, vg_ack, vg_rvalid, vg_rdata,
        output bram_en, bram_we, bram_addr, bram_din, cpu_starved
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, vg_req, vg_addr, bram_dout,
        input  cpu_ack, vg_ack, vg_rvalid, vg_rdata,
        input  bram_en, bram_we, bram_addr, bram_din, cpu_starved
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port vector RAM arbiter, VG priority with bounded CPU starvation
module vram_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int MAX_CPU_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    vram_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_CPU_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       starved_q, starved_d;
    logic       rd_pend_q;
    logic [7:0] hold_q, hold_d;
    logic       cpu_ack;
    logic       vg_ack;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^bus.cpu_addr[15:ADDR_W];

    // VG wins unless the CPU has already been denied MAX_CPU_WAIT times in a row
    always_comb begin
        cpu_ack = 1'b0;
        vg_ack  = 1'b0;
        if (!rst) begin
            if (bus.cpu_req && (!bus.vg_req || wait_cnt_q == WAIT_MAX)) begin
                cpu_ack = 1'b1;
            end else if (bus.vg_req) begin
                vg_ack = 1'b1;
            end
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (bus.cpu_req && !cpu_ack) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
        starved_d = (wait_cnt_d == WAIT_MAX);
        hold_d    = rd_pend_q ? bus.bram_dout : hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            starved_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            starved_q  <= starved_d;
            rd_pend_q  <= vg_ack;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        bus.bram_en   = 1'b0;
        bus.bram_we   = 1'b0;
        bus.bram_addr = '0;
        bus.bram_din  = '0;
        if (cpu_ack) begin
            bus.bram_en   = 1'b1;
            bus.bram_we   = 1'b1;
            bus.bram_addr = bus.cpu_addr[ADDR_W-1:0];
            bus.bram_din  = bus.cpu_wdata;
        end else if (vg_ack) begin
            bus.bram_en   = 1'b1;
            bus.bram_addr = bus.vg_addr;
        end
    end

    // Registered state is masked while rst is high so a read acked just before reset never returns
    assign bus.cpu_ack     = cpu_ack;
    assign bus.vg_ack      = vg_ack;
    assign bus.vg_rvalid   = rd_pend_q & ~rst;
    assign bus.vg_rdata    = rst ? 8'h00 : (rd_pend_q ? bus.bram_dout : hold_q);
    assign bus.cpu_starved = starved_q & ~rst;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed and randomized checks of vram_arbiter against a behavioural model
module tb_vram_arbiter;
    localparam int AW   = 13;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW)) bus ();

    vram_arbiter #(.ADDR_W(AW), .MAX_CPU_WAIT(MAXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous-read BRAM
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.bram_en) begin
            if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
            else             bus.bram_dout <= mem[bus.bram_addr];
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: consecutive-denial count, one outstanding read, last returned byte, memory image
    int         m_wait;
    bit         m_pend;
    logic [7:0] m_pend_data;
    logic [7:0] m_last;
    logic [7:0] ref_mem [0:(1<<AW)-1];
    bit         e_cpu;
    bit         e_vg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit cr, input logic [15:0] ca, input logic [7:0] cd,
                         input bit vr, input logic [12:0] va);
        rst           = r;
        bus.cpu_req   = cr;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.vg_req    = vr;
        bus.vg_addr   = va;
        #2;
    endtask

    task automatic model_step();
        bit          e_starved;
        bit          e_rvalid;
        logic [7:0]  e_rdata;
        logic [12:0] e_addr;
        logic [7:0]  e_din;
        if (rst) begin
            e_cpu = 0; e_vg = 0; e_starved = 0; e_rvalid = 0; e_rdata = 8'h00;
        end else begin
            e_starved = (m_wait >= MAXW);
            e_cpu     = bus.cpu_req && (!bus.vg_req || e_starved);
            e_vg      = bus.vg_req && !e_cpu;
            e_rvalid  = m_pend;
            e_rdata   = m_pend ? m_pend_data : m_last;
        end
        e_addr = e_cpu ? bus.cpu_addr[12:0] : (e_vg ? bus.vg_addr : 13'h0);
        e_din  = e_cpu ? bus.cpu_wdata : 8'h00;
        chk("cpu_ack",     bus.cpu_ack,     e_cpu);
        chk("vg_ack",      bus.vg_ack,      e_vg);
        chk("vg_rvalid",   bus.vg_rvalid,   e_rvalid);
        chk("vg_rdata",    bus.vg_rdata,    e_rdata);
        chk("bram_en",     bus.bram_en,     e_cpu | e_vg);
        chk("bram_we",     bus.bram_we,     e_cpu);
        chk("bram_addr",   bus.bram_addr,   e_addr);
        chk("bram_din",    bus.bram_din,    e_din);
        chk("cpu_starved", bus.cpu_starved, e_starved);
        chk("ack_excl",    bus.cpu_ack & bus.vg_ack, 1'b0);
        if (rst) begin
            m_wait = 0; m_pend = 0; m_last = 8'h00;
        end else begin
            if (m_pend) m_last = m_pend_data;
            m_pend = e_vg;
            if (e_vg)  m_pend_data = ref_mem[bus.vg_addr];
            if (e_cpu) ref_mem[bus.cpu_addr[12:0]] = bus.cpu_wdata;
            if (bus.cpu_req && !e_cpu) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
            else                       m_wait = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 16'h2000, 8'h00, 0, 13'h0);
        model_step();
    endtask

    initial begin
        bit          c_pend;
        bit          v_pend;
        bit          r;
        logic [15:0] c_a;
        logic [7:0]  c_d;
        logic [12:0] v_a;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'h00;
        m_wait = 0; m_pend = 0; m_pend_data = 8'h00; m_last = 8'h00;

        // Reset state
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 16'h2001, 8'h11, 1, 13'h1);
            chk("rst_cpu_ack", bus.cpu_ack, 1'b0);
            chk("rst_vg_ack",  bus.vg_ack,  1'b0);
            model_step();
        end
        idle();

        // CPU only
        drive(0, 1, 16'h2005, 8'hA5, 0, 13'h0);
        chk("t1_cpu_ack", bus.cpu_ack, 1'b1);
        chk("t1_we",      bus.bram_we, 1'b1);
        chk("t1_addr",    bus.bram_addr, 13'h0005);
        chk("t1_din",     bus.bram_din, 8'hA5);
        model_step();
        idle();

        // Write then read
        drive(0, 1, 16'h2010, 8'h3C, 0, 13'h0);
        model_step();
        drive(0, 0, 16'h2000, 8'h00, 1, 13'h0010);
        chk("t2_vg_ack", bus.vg_ack, 1'b1);
        model_step();
        drive(0, 0, 16'h2000, 8'h00, 0, 13'h0);
        chk("t2_rvalid", bus.vg_rvalid, 1'b1);
        chk("t2_rdata",  bus.vg_rdata, 8'h3C);
        model_step();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 16'h2000, 8'h00, 0, 13'h0);
            chk("t2_hold_rvalid", bus.vg_rvalid, 1'b0);
            chk("t2_hold_rdata",  bus.vg_rdata, 8'h3C);
            model_step();
        end

        // Contention
        for (int c = 0; c < 9; c++) begin
            drive(0, 1, 16'h2100, 8'h77, 1, 13'h0010);
            chk("t3_vg_ack",  bus.vg_ack,      (c != 4));
            chk("t3_cpu_ack", bus.cpu_ack,     (c == 4));
            chk("t3_starved", bus.cpu_starved, (c == 4));
            model_step();
        end
        idle();

        // Streaming reads of a preloaded block
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 16'h2000 + 16'(i), 8'h10 + 8'(i), 0, 13'h0);
            model_step();
        end
        for (int c = 0; c < 9; c++) begin
            drive(0, 0, 16'h2000, 8'h00, (c < 8), 13'(c));
            if (c >= 1) begin
                chk("t4_rvalid", bus.vg_rvalid, 1'b1);
                chk("t4_rdata",  bus.vg_rdata, 8'h10 + 8'(c - 1));
            end
            model_step();
        end

        // Reset mid-read
        drive(0, 0, 16'h2000, 8'h00, 1, 13'h3);
        chk("t5_vg_ack", bus.vg_ack, 1'b1);
        model_step();
        drive(1, 0, 16'h2000, 8'h00, 1, 13'h3);
        chk("t5_rvalid_rst", bus.vg_rvalid, 1'b0);
        chk("t5_rdata_rst",  bus.vg_rdata, 8'h00);
        model_step();
        drive(0, 0, 16'h2000, 8'h00, 0, 13'h0);
        chk("t5_rvalid_after", bus.vg_rvalid, 1'b0);
        chk("t5_rdata_after",  bus.vg_rdata, 8'h00);
        chk("t5_en_after",     bus.bram_en, 1'b0);
        model_step();

        // Request drop
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 16'h2200, 8'h5A, 1, 13'h0010);
            chk("t6_denied", bus.cpu_ack, 1'b0);
            model_step();
        end
        drive(0, 0, 16'h2200, 8'h5A, 1, 13'h0010);
        model_step();
        for (int c = 0; c < 5; c++) begin
            drive(0, 1, 16'h2200, 8'h5A, 1, 13'h0010);
            chk("t6_vg_ack",  bus.vg_ack,  (c < 4));
            chk("t6_cpu_ack", bus.cpu_ack, (c == 4));
            model_step();
        end
        idle();

        // Randomized traffic obeying the requester hold rule
        c_pend = 0; v_pend = 0; c_a = 16'h2000; c_d = 8'h00; v_a = 13'h0;
        for (int n = 0; n < 800; n++) begin
            if (!c_pend && $urandom_range(0, 2) == 0) begin
                c_pend = 1;
                c_a    = 16'h2000 | 16'($urandom_range(0, 7));
                c_d    = 8'($urandom);
            end else if (c_pend && $urandom_range(0, 9) == 0) begin
                c_pend = 0;
            end
            if (!v_pend && $urandom_range(0, 3) != 0) begin
                v_pend = 1;
                v_a    = 13'($urandom_range(0, 7));
            end
            r = ($urandom_range(0, 49) == 0);
            drive(r, c_pend, c_a, c_d, v_pend, v_a);
            model_step();
            if (e_cpu) c_pend = 0;
            if (e_vg)  v_pend = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
